series_input_buffer: RTL and testbench

//  First-word-fall-through staging FIFO directly upstream of the series-evaluation controller.

---
 rtl/series_input_buffer.sv | 52 +++++
 tb/tb_series_input_buffer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/series_input_buffer.sv
// series_input_buffer: FWFT staging FIFO with sticky overflow flag ahead of the series controller
module series_input_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              in_valid,
  output logic [DATA_W-1:0] x_out,
  input  logic              dst_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf_err
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              push, pop;
  always_comb begin
    empty     = wr_ptr == rd_ptr;
    full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    count     = wr_ptr - rd_ptr;
    src_ready = !full;
    in_valid  = !empty;
    x_out     = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    push      = src_valid && !full && !clear;
    pop       = !empty && dst_ready && !clear;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + (ADDR_W+1)'(push);
      rd_ptr  <= rd_ptr + (ADDR_W+1)'(pop);
      ovf_err <= ovf_err | (src_valid && full);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= src_data;
  end
endmodule

// File: tb/tb_series_input_buffer.sv
// tb_series_input_buffer: randomized scoreboard bench against a queue-level FIFO model
module tb_series_input_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 1;
  logic clear = 0, src_valid = 0, dst_ready = 0;
  logic [DW-1:0] src_data = '0;
  logic src_ready, in_valid, full, empty, ovf_err;
  logic [DW-1:0] x_out;
  logic [2:0] count;
  int total = 0, bad = 0;
  int mcnt = 0;
  bit movf = 0;
  logic [DW-1:0] sb [$];

  series_input_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .in_valid(in_valid), .x_out(x_out), .dst_ready(dst_ready),
    .count(count), .full(full), .empty(empty), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: occupancy and overflow flag derived from the queueing rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt = 0; movf = 0; sb.delete();
    end else if (clear) begin
      mcnt = 0; movf = 0; sb.delete();
    end else begin
      int pushed, popped;
      pushed = (src_valid && mcnt < DEPTH) ? 1 : 0;
      popped = (dst_ready && mcnt > 0) ? 1 : 0;
      if (src_valid && mcnt == DEPTH) movf = 1;
      if (pushed == 1) sb.push_back(src_data);
      mcnt = mcnt + pushed - popped;
    end
  end

  // monitor: every handshake must present the oldest accepted sample
  always @(negedge clk) begin
    #2;
    if (!rst && in_valid && dst_ready) begin
      if (sb.size() == 0) check("pop_on_empty_model", 1, 0);
      else check("x_out_order", x_out, sb.pop_front());
    end
  end

  // status checker against model
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("count", count, mcnt);
      check("full", full, mcnt == DEPTH);
      check("empty", empty, mcnt == 0);
      check("src_ready", src_ready, mcnt != DEPTH);
      check("in_valid", in_valid, mcnt != 0);
      check("ovf_err", ovf_err, movf);
      if (mcnt == 0) check("x_out_zero", x_out, 0);
    end
  end

  task automatic cyc(input logic sv, input logic [DW-1:0] d, input logic dr, input logic clr);
    @(negedge clk); #1;
    src_valid = sv; src_data = d; dst_ready = dr; clear = clr;
  endtask

  initial begin
    logic [DW-1:0] fill [4];
    fill[0] = 16'h0011; fill[1] = 16'h0022; fill[2] = 16'h0033; fill[3] = 16'h0044;
    #12 rst = 0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_src_ready", src_ready, 1);
    check("rst_in_valid", in_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_ovf", ovf_err, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, fill[i], 0, 0);
    cyc(0, 0, 0, 0);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_src_ready", src_ready, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, DW'(16'h0100 + i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, fill[i], 0, 0);
    cyc(1, 16'hBEEF, 0, 0);
    cyc(0, 0, 0, 0);
    check("ovf_set", ovf_err, 1);
    check("ovf_count", count, 4);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    check("ovf_sticky", ovf_err, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("ovf_cleared", ovf_err, 0);
    cyc(1, 16'h0A0A, 0, 0);
    cyc(1, 16'h0B0B, 0, 0);
    cyc(1, 16'h0C0C, 1, 1);
    cyc(0, 0, 0, 0);
    check("clr_count", count, 0);
    check("clr_in_valid", in_valid, 0);
    for (int i = 0; i < 3; i++) cyc(1, DW'(16'h0200 + i), 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk); #3;
    rst = 1;
    #1;
    check("arst_in_valid", in_valid, 0);
    check("arst_count", count, 0);
    #1 rst = 0;
    cyc(1, 16'h1234, 0, 0);
    cyc(0, 0, 0, 0);
    check("post_rst_in_valid", in_valid, 1);
    check("post_rst_x_out", x_out, 16'h1234);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    @(negedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
